// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant, per-requester burst of
// weight+1 cycles, rotating priority pointer, gated by a global go enable.
module wrr_arbiter #(
    parameter int N_REQ    = 8,
    parameter int WEIGHT_W = 3,
    parameter int IDX_W    = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      go,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WEIGHT_W-1:0] weight,
    output logic [N_REQ-1:0]          grant,
    output logic                      grant_vld,
    output logic [IDX_W-1:0]          grant_idx
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    ptr, ptr_nxt, ptr_rot, idx_nxt, search_base, sel;
    logic [WEIGHT_W-1:0] burst_cnt, cnt_nxt, w_own;
    logic [N_REQ-1:0]    grant_nxt;
    logic                found;

    // First set request bit at or after base, wrapping modulo N_REQ; MSB flags a hit.
    function automatic logic [IDX_W:0] pick(input logic [N_REQ-1:0] r,
                                            input logic [IDX_W-1:0] base);
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] k;
        int               j;
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(base) + i;
            if (j >= N_REQ) j = j - N_REQ;
            k = IDX_W'(j);
            if (!hit && r[k]) begin
                hit = 1'b1;
                idx = k;
            end
        end
        return {hit, idx};
    endfunction

    always_comb begin
        w_own = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) w_own = weight[i*WEIGHT_W +: WEIGHT_W];
        end
    end

    assign ptr_rot     = (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
    // While owning, a rotation searches from the owner's successor in the same edge.
    assign search_base = (state == OWN) ? ptr_rot : ptr;
    assign {found, sel} = pick(req, search_base);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = burst_cnt;
        grant_nxt = '0;
        idx_nxt   = grant_idx;
        case (state)
            IDLE: begin
                if (go && found) begin
                    grant_nxt[sel] = 1'b1;
                    idx_nxt        = sel;
                    cnt_nxt        = '0;
                    state_nxt      = OWN;
                end
            end
            OWN: begin
                if (!go) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (req[grant_idx] && (burst_cnt < w_own)) begin
                    grant_nxt = grant;
                    cnt_nxt   = burst_cnt + WEIGHT_W'(1);
                end else begin
                    // Burst over or owner left: rotate, switching directly if anyone waits.
                    ptr_nxt = ptr_rot;
                    cnt_nxt = '0;
                    if (found) begin
                        grant_nxt[sel] = 1'b1;
                        idx_nxt        = sel;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            burst_cnt <= '0;
            grant     <= '0;
            grant_idx <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            burst_cnt <= cnt_nxt;
            grant     <= grant_nxt;
            grant_idx <= idx_nxt;
        end
    end

    assign grant_vld = |grant;

endmodule
